seq_frame_scanner: RTL and testbench

//  Controller that sequences a serial pattern detector over parallel frames.
//  - Accepts one FRAME_W-bit frame per valid/ready handshake.
//  - Shifts the frame MSB-first, one bit per cycle, into sub-module seq_detect_core (PATTERN, PAT_W bits).
//  - Counts detections and reports the result with a one-cycle done pulse.
//  - Sits between a word-oriented producer and the bit-serial detector datapath.

---
 rtl/seq_scan_pkg.sv | 14 +
 rtl/seq_detect_core.sv | 54 +++++
 rtl/seq_frame_scanner.sv | 132 +++++++++++++
 tb/tb_seq_frame_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared state encoding and default pattern for the frame scanner
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int                   PAT_W_DEF   = 7;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 7'b1011101;

endpackage

// File: rtl/seq_detect_core.sv
// rtl/seq_detect_core.sv - bit-serial pattern detector (window, fill, match register); SEQ_OVERLAP_EN selects overlapping matches
module seq_detect_core
    import seq_scan_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift_en,
    input  logic ser_bit,
    output logic match_pulse
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  window_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              hit;

    // Window and fill as they will be after this bit; fill saturates once the window is full
    always_comb begin
        window_nxt = {window[PAT_W-2:0], ser_bit};
        fill_nxt   = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        hit        = shift_en && (window_nxt == PATTERN) && (fill_nxt >= FILL_W'(PAT_W));
    end

    // Window/fill update and registered match pulse; clear wins over shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window      <= '0;
            fill        <= '0;
            match_pulse <= 1'b0;
        end else if (clear) begin
            window      <= '0;
            fill        <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= hit;
            if (shift_en) begin
                window <= window_nxt;
`ifdef SEQ_OVERLAP_EN
                fill   <= fill_nxt;
`else
                fill   <= hit ? '0 : fill_nxt;
`endif
            end
        end
    end

endmodule

// File: rtl/seq_frame_scanner.sv
// rtl/seq_frame_scanner.sv - frame-to-serial controller around seq_detect_core; SEQ_OVERLAP_EN selects overlapping matches
module seq_frame_scanner
    import seq_scan_pkg::*;
#(
    parameter int               FRAME_W = 16,
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int               CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               frame_ready,
    input  logic               abort,
    output logic               ser_bit,
    output logic               busy,
    output logic               match_pulse,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               first_vld,
    output logic [CNT_W-1:0]   first_pos
);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_idx;
    logic               accept;
    logic               abort_scan;
    logic               core_clear;
    logic               shift_en;

    assign shift_en   = (state == SHIFT);
    assign ser_bit    = shift_en ? shreg[FRAME_W-1] : 1'b0;
    assign core_clear = accept | abort_scan;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state outputs; abort only matters while a scan is running
    always_comb begin
        state_nxt   = state;
        frame_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        abort_scan  = 1'b0;
        case (state)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    abort_scan = 1'b1;
                    state_nxt  = IDLE;
                end else if (bit_idx == CNT_W'(FRAME_W - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    abort_scan = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit index and result counters; a match pulse refers to bit_idx-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            first_vld <= 1'b0;
            first_pos <= '0;
        end else if (core_clear) begin
            shreg     <= accept ? frame_data : '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            first_vld <= 1'b0;
            first_pos <= '0;
        end else begin
            if (shift_en) begin
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                bit_idx <= bit_idx + CNT_W'(1);
            end
            if (match_pulse) begin
                if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                if (!first_vld) begin
                    first_vld <= 1'b1;
                    first_pos <= bit_idx - CNT_W'(1);
                end
            end
        end
    end

    seq_detect_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (core_clear),
        .shift_en    (shift_en),
        .ser_bit     (ser_bit),
        .match_pulse (match_pulse)
    );

endmodule

// File: tb/tb_seq_frame_scanner.sv
// tb/tb_seq_frame_scanner.sv - self-checking bench for seq_frame_scanner; honours SEQ_OVERLAP_EN
module tb_seq_frame_scanner;

    localparam int         FW    = 16;
    localparam int         PW    = 7;
    localparam int         CW    = 5;
    localparam logic [6:0] PAT   = 7'b1011101;
`ifdef SEQ_OVERLAP_EN
    localparam bit         OVL   = 1'b1;
`else
    localparam bit         OVL   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_valid = 1'b0;
    logic [FW-1:0] frame_data = '0;
    logic          frame_ready;
    logic          abort = 1'b0;
    logic          ser_bit;
    logic          busy;
    logic          match_pulse;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          first_vld;
    logic [CW-1:0] first_pos;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_frame_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .abort       (abort),
        .ser_bit     (ser_bit),
        .busy        (busy),
        .match_pulse (match_pulse),
        .done        (done),
        .match_cnt   (match_cnt),
        .first_vld   (first_vld),
        .first_pos   (first_pos)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan bits MSB-first; a match ends at bit i when bits i-6..i equal PAT and,
    // without overlap, all seven bits are newer than the previous match.
    // The pulse for bit i is visible in cycle i+2 after the accepting edge.
    function automatic void model(input logic [FW-1:0] d, output int cnt, output int fpos,
                                  output bit fvld, output logic [0:31] pulses);
        int last_end;
        cnt = 0; fpos = 0; fvld = 1'b0; pulses = '0; last_end = -1;
        for (int i = PW - 1; i < FW; i++) begin
            if (d[(FW-1-i) +: PW] == PAT && (OVL || (i - PW + 1) > last_end)) begin
                cnt++;
                last_end = i;
                pulses[i+2] = 1'b1;
                if (!fvld) begin
                    fvld = 1'b1;
                    fpos = i;
                end
            end
        end
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, frame_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt"}, match_cnt, 0);
        chk({tag, "_fvld"}, first_vld, 0);
        chk({tag, "_fpos"}, first_pos, 0);
        chk({tag, "_mp"}, match_pulse, 0);
        chk({tag, "_ser"}, ser_bit, 0);
    endtask

    // Called at a negedge with the DUT idle; abort_cyc = 0 means no abort
    task automatic run_frame(input logic [FW-1:0] d, input int abort_cyc,
                             input bit abort_idle, input bit abort_rep);
        int          cnt, fpos;
        bit          fvld;
        logic [0:31] pulses;
        model(d, cnt, fpos, fvld, pulses);
        chk("ready_before_accept", frame_ready, 1);
        frame_valid = 1'b1;
        frame_data  = d;
        abort       = abort_idle;
        @(negedge clk);
        frame_valid = 1'b0;
        abort       = 1'b0;
        frame_data  = 16'($urandom);
        for (int n = 1; n <= FW + 2; n++) begin
            if (n > 1) @(negedge clk);
            if (abort_cyc != 0 && n == abort_cyc + 1) begin
                abort = 1'b0;
                chk_cleared("abort");
                return;
            end
            chk("ser_bit", ser_bit, (n <= FW) ? d[FW-n] : 1'b0);
            chk("busy", busy, n <= FW + 1);
            chk("ready_low", frame_ready, 0);
            chk("done", done, n == FW + 2);
            chk("match_pulse", match_pulse, pulses[n]);
            if (n == abort_cyc) abort = 1'b1;
        end
        chk("match_cnt", match_cnt, cnt);
        chk("first_vld", first_vld, fvld);
        chk("first_pos", first_pos, fpos);
        abort = abort_rep;
        @(negedge clk);
        abort = 1'b0;
        chk("done_gone", done, 0);
        chk("ready_back", frame_ready, 1);
        chk("hold_cnt", match_cnt, cnt);
        chk("hold_fvld", first_vld, fvld);
        chk("hold_fpos", first_pos, fpos);
    endtask

    initial begin
        int          acc_cyc[$];
        logic [FW-1:0] d;
        int          pos;

        repeat (2) @(negedge clk);
        chk_cleared("reset");
        chk("reset_ready", frame_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single match at the front
        run_frame(16'hBA00, 0, 1'b0, 1'b0);
        chk("t1_cnt", match_cnt, 1);
        chk("t1_pos", first_pos, 6);

        // Overlapping candidate pair
        run_frame(16'hBAE8, 0, 1'b0, 1'b0);
        chk("t2_cnt", match_cnt, OVL ? 2 : 1);

        // No match; abort in REPORT must not disturb results
        run_frame(16'h0000, 0, 1'b0, 1'b1);
        chk("t3_fvld", first_vld, 0);

        // abort during IDLE is ignored
        run_frame(16'h05D0, 0, 1'b1, 1'b0);

        // Abort in the 5th SHIFT cycle, then an immediate new frame
        run_frame(16'hBA00, 5, 1'b0, 1'b0);
        run_frame(16'h05D0, 0, 1'b0, 1'b0);
        chk("t4_cnt", match_cnt, 1);
        chk("t4_pos", first_pos, 11);

        // Abort in DRAIN
        run_frame(16'h005D, FW + 1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SHIFT, after a live match
        frame_valid = 1'b1;
        frame_data  = 16'hBA00;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_cnt", match_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cleared("after_reset");

        // Randomised frames, some seeded with the pattern, some aborted
        for (int k = 0; k < 24; k++) begin
            d = 16'($urandom);
            if (k % 2 == 0) begin
                pos = $urandom_range(0, FW - PW);
                d[(FW-1-pos) -: PW] = PAT;
            end
            run_frame(d, (k % 6 == 5) ? int'($urandom_range(1, FW + 1)) : 0, 1'b0, 1'b0);
        end

        // frame_valid held high: accepts happen only in IDLE
        frame_valid = 1'b1;
        frame_data  = 16'hBA00;
        for (int c = 0; c < 60; c++) begin
            if (frame_ready) acc_cyc.push_back(c);
            @(negedge clk);
        end
        frame_valid = 1'b0;
        chk("b2b_accepts", (acc_cyc.size() >= 3), 1);
        if (acc_cyc.size() >= 3) begin
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], FW + 3);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], FW + 3);
        end
        repeat (FW + 4) @(negedge clk);
        chk("b2b_final_cnt", match_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
